// File: rtl/hp_bar_control.sv
// hp_bar_control: player HP state machine with frame-counted invulnerability and a segmented HP bar overlay
//
// Ports:
//   pclk, rst                      pixel clock, synchronous active-high reset
//   hcount_in/vcount_in/...        upstream VGA stream (position, syncs, blanking, rgb)
//   game_on                        level, high while a game runs
//   player_hit, heal               requests, each acts on its rising edge
//   hcount_out/.../rgb_out         stream delayed one pclk, rgb with the bar overlaid
//   hp, invulnerable, game_over    registered player status
module hp_bar_control #(
  parameter int MAX_HP = 8,
  parameter int HP_W = 4,
  parameter int IFRAME_FRAMES = 60,
  parameter int LOW_HP = 2,
  parameter int BAR_X = 361,
  parameter int BAR_Y = 290,
  parameter int SEG_W = 36,
  parameter int SEG_GAP = 2,
  parameter int SEG_H = 16,
  parameter logic [11:0] BAR_COLOR = 12'h0F0,
  parameter logic [11:0] LOW_COLOR = 12'hF00,
  parameter logic [11:0] OFF_COLOR = 12'h333
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic [11:0]     hcount_in,
  input  logic [11:0]     vcount_in,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic            hblnk_in,
  input  logic            vblnk_in,
  input  logic [11:0]     rgb_in,
  input  logic            game_on,
  input  logic            player_hit,
  input  logic            heal,
  output logic [11:0]     hcount_out,
  output logic [11:0]     vcount_out,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic            hblnk_out,
  output logic            vblnk_out,
  output logic [11:0]     rgb_out,
  output logic [HP_W-1:0] hp,
  output logic            invulnerable,
  output logic            game_over
);
  // at least 3 bits so the blink bit always exists
  localparam int CW = $clog2(IFRAME_FRAMES + 1) < 3 ? 3 : $clog2(IFRAME_FRAMES + 1);
  localparam logic [HP_W-1:0] HP_MAX = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] HP_LOW = HP_W'(LOW_HP);
  localparam logic [CW-1:0] IFR = CW'(IFRAME_FRAMES);
  localparam logic [11:0] YT = 12'(BAR_Y);
  localparam logic [11:0] YB = 12'(BAR_Y + SEG_H - 1);
  typedef enum logic [1:0] {IDLE, PLAYING, INVULN, DEAD} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic hit_q, heal_q, vs_q;
  logic hit_ev, heal_ev, tick, can_heal;
  assign hit_ev = player_hit & ~hit_q;
  assign heal_ev = heal & ~heal_q;
  assign tick = vsync_in & ~vs_q;
  assign can_heal = heal_ev && hp < HP_MAX;
  // an edge seen on the first cycle after reset lands in IDLE and is discarded
  always_ff @(posedge pclk) begin
    if (rst) begin
      st <= IDLE;
      hp <= HP_MAX;
      cnt <= '0;
      invulnerable <= 1'b0;
      game_over <= 1'b0;
      hit_q <= 1'b0;
      heal_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      hit_q <= player_hit;
      heal_q <= heal;
      vs_q <= vsync_in;
      if (!game_on) begin
        st <= IDLE;
        hp <= HP_MAX;
        invulnerable <= 1'b0;
        game_over <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            st <= PLAYING;
            hp <= HP_MAX;
          end
          PLAYING: begin
            if (hit_ev) begin
              if (hp <= HP_W'(1)) begin
                hp <= '0;
                st <= DEAD;
                game_over <= 1'b1;
              end else begin
                hp <= hp - 1'b1;
                cnt <= IFR;
                st <= INVULN;
                invulnerable <= 1'b1;
              end
            end else if (can_heal) hp <= hp + 1'b1;
          end
          INVULN: begin
            if (can_heal) hp <= hp + 1'b1;
            if (tick) begin
              cnt <= cnt - 1'b1;
              if (cnt <= CW'(1)) begin
                st <= PLAYING;
                invulnerable <= 1'b0;
              end
            end
          end
          default: hp <= '0;
        endcase
      end
    end
  end
  logic [MAX_HP-1:0] in_seg, lit_seg;
  logic in_row, on_bar, lit, blink;
  logic [11:0] rgb_n;
  genvar i;
  generate
    for (i = 0; i < MAX_HP; i++) begin : g_seg
      localparam logic [11:0] XL = 12'(BAR_X + i * (SEG_W + SEG_GAP));
      localparam logic [11:0] XR = 12'(BAR_X + i * (SEG_W + SEG_GAP) + SEG_W - 1);
      localparam logic [HP_W-1:0] IDX = HP_W'(i);
      assign in_seg[i] = hcount_in >= XL && hcount_in <= XR;
      assign lit_seg[i] = IDX < hp;
    end
  endgenerate
  assign in_row = vcount_in >= YT && vcount_in <= YB;
  assign on_bar = in_row && |in_seg;
  assign lit = |(in_seg & lit_seg);
  // lit segments flash off during frames where counter bit 2 is set
  assign blink = st == INVULN && cnt[2];
  assign rgb_n = (hblnk_in || vblnk_in) ? 12'h000 :
                 (st == IDLE || !on_bar || (lit && blink)) ? rgb_in :
                 !lit ? OFF_COLOR :
                 hp <= HP_LOW ? LOW_COLOR : BAR_COLOR;
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      hblnk_out <= 1'b0;
      vblnk_out <= 1'b0;
      rgb_out <= '0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      hblnk_out <= hblnk_in;
      vblnk_out <= vblnk_in;
      rgb_out <= rgb_n;
    end
  end
endmodule

// File: tb/tb_hp_bar_control.sv
// tb_hp_bar_control: table vectors, hand sequences and a video scoreboard for hp_bar_control
module tb_hp_bar_control;
  logic pclk = 1'b0;
  logic rst, hsync_in, vsync_in, hblnk_in, vblnk_in, game_on, player_hit, heal;
  logic [11:0] hcount_in, vcount_in, rgb_in;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out, invulnerable, game_over;
  logic [3:0] hp;
  always #5 pclk = ~pclk;
  hp_bar_control dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .game_on(game_on), .player_hit(player_hit), .heal(heal),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
    .hp(hp), .invulnerable(invulnerable), .game_over(game_over)
  );
  typedef struct packed {logic [11:0] h, v; logic hs, vs, hb, vb; logic [11:0] rgb;} vid_t;
  typedef struct packed {logic [11:0] h, v, rgb; logic hb, vb; logic [11:0] e8, e1;} vec_t;
  vec_t tbl [12];
  vid_t sb [$];
  int n_chk = 0, n_fail = 0;
  logic rand_vid;
  logic k_idle, k_inv, k_dead;
  int k_hp, k_cnt;
  function automatic logic [11:0] model_rgb(logic [11:0] h, logic [11:0] v, logic [11:0] rgb, logic hb, logic vb);
    int d, s;
    if (hb || vb) return 12'h000;
    if (k_idle || v < 12'd290 || v > 12'd305 || h < 12'd361) return rgb;
    d = int'(h) - 361;
    s = d / 38;
    if (s >= 8 || d % 38 >= 36) return rgb;
    if (s >= k_hp) return 12'h333;
    if (k_inv && (k_cnt & 4) != 0) return rgb;
    return k_hp <= 2 ? 12'hF00 : 12'h0F0;
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_st(string n, int e_hp, logic e_inv, logic e_ov);
    chk(n, {hp, invulnerable, game_over}, {4'(e_hp), e_inv, e_ov});
  endtask
  task automatic step();
    vid_t e, a;
    if (rand_vid) begin
      hcount_in = 12'(340 + $urandom_range(0, 340));
      vcount_in = 12'(285 + $urandom_range(0, 25));
      hsync_in = 1'($urandom);
      hblnk_in = $urandom_range(0, 7) == 0;
      vblnk_in = $urandom_range(0, 7) == 0;
      rgb_in = 12'($urandom);
    end
    e = rst ? '0 : {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
                    model_rgb(hcount_in, vcount_in, rgb_in, hblnk_in, vblnk_in)};
    sb.push_back(e);
    @(posedge pclk);
    #1;
    a = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    chk("video", 64'(a), 64'(sb.pop_front()));
  endtask
  task automatic model_hit();
    if (!k_idle && !k_dead && !k_inv) begin
      if (k_hp == 1) begin
        k_hp = 0;
        k_dead = 1;
      end else begin
        k_hp--;
        k_inv = 1;
        k_cnt = 60;
      end
    end
  endtask
  task automatic frame();
    vsync_in = 1;
    step();
    if (k_inv) begin
      if (k_cnt == 1) k_inv = 0;
      k_cnt--;
    end
    vsync_in = 0;
    step();
  endtask
  task automatic run_frames(int n);
    repeat (n) frame();
  endtask
  task automatic pulse_hit();
    player_hit = 1;
    step();
    model_hit();
    player_hit = 0;
    step();
  endtask
  task automatic pulse_heal();
    heal = 1;
    step();
    if (!k_idle && !k_dead && k_hp < 8) k_hp++;
    heal = 0;
    step();
  endtask
  task automatic run_table(int low);
    rand_vid = 0;
    foreach (tbl[j]) begin
      hcount_in = tbl[j].h;
      vcount_in = tbl[j].v;
      rgb_in = tbl[j].rgb;
      hblnk_in = tbl[j].hb;
      vblnk_in = tbl[j].vb;
      step();
      chk(low != 0 ? "tbl_hp1" : "tbl_hp8", rgb_out, low != 0 ? tbl[j].e1 : tbl[j].e8);
    end
    rand_vid = 1;
  endtask
  initial begin
    tbl[0]  = '{12'd361, 12'd290, 12'hABC, 1'b0, 1'b0, 12'h0F0, 12'hF00};
    tbl[1]  = '{12'd399, 12'd290, 12'hABC, 1'b0, 1'b0, 12'h0F0, 12'h333};
    tbl[2]  = '{12'd397, 12'd290, 12'hABC, 1'b0, 1'b0, 12'hABC, 12'hABC};
    tbl[3]  = '{12'd396, 12'd305, 12'hABC, 1'b0, 1'b0, 12'h0F0, 12'hF00};
    tbl[4]  = '{12'd396, 12'd306, 12'hABC, 1'b0, 1'b0, 12'hABC, 12'hABC};
    tbl[5]  = '{12'd360, 12'd290, 12'hABC, 1'b0, 1'b0, 12'hABC, 12'hABC};
    tbl[6]  = '{12'd361, 12'd289, 12'hABC, 1'b0, 1'b0, 12'hABC, 12'hABC};
    tbl[7]  = '{12'd662, 12'd300, 12'hABC, 1'b0, 1'b0, 12'h0F0, 12'h333};
    tbl[8]  = '{12'd663, 12'd300, 12'hABC, 1'b0, 1'b0, 12'hABC, 12'hABC};
    tbl[9]  = '{12'd361, 12'd290, 12'hABC, 1'b1, 1'b0, 12'h000, 12'h000};
    tbl[10] = '{12'd361, 12'd290, 12'hABC, 1'b0, 1'b1, 12'h000, 12'h000};
    tbl[11] = '{12'd437, 12'd297, 12'hABC, 1'b0, 1'b0, 12'h0F0, 12'h333};
    rst = 1; game_on = 0; player_hit = 0; heal = 0; vsync_in = 0; rand_vid = 1;
    k_idle = 1; k_inv = 0; k_dead = 0; k_hp = 8; k_cnt = 0;
    step();
    step();
    chk_st("reset", 8, 0, 0);
    rst = 0;
    step();
    chk_st("idle", 8, 0, 0);
    game_on = 1;
    step();
    k_idle = 0;
    chk_st("play", 8, 0, 0);
    run_table(0);
    pulse_heal();
    chk_st("heal_at_max", 8, 0, 0);
    rand_vid = 0;
    hcount_in = 12'd361; vcount_in = 12'd290; hblnk_in = 0; vblnk_in = 0; rgb_in = 12'h5A5;
    player_hit = 1;
    step();
    model_hit();
    chk_st("hit1", 7, 1, 0);
    player_hit = 0;
    step();
    chk("blink_on", rgb_out, 12'h5A5);
    frame();
    step();
    chk("blink_off", rgb_out, 12'h0F0);
    rand_vid = 1;
    for (int f = 2; f <= 60; f++) begin
      frame();
      chk_st("iframe_len", 7, f < 60, 0);
      if (f == 10) begin
        pulse_hit();
        chk_st("hit_in_iframe", 7, 1, 0);
      end
    end
    pulse_hit();
    chk_st("hit_after_expiry", 6, 1, 0);
    run_frames(59);
    chk_st("pre_expiry", 6, 1, 0);
    player_hit = 1;
    frame();
    player_hit = 0;
    step();
    chk_st("hit_at_expiry", 6, 0, 0);
    pulse_hit();
    chk_st("hit3", 5, 1, 0);
    run_frames(60);
    chk_st("expire3", 5, 0, 0);
    player_hit = 1;
    heal = 1;
    step();
    model_hit();
    player_hit = 0;
    heal = 0;
    step();
    chk_st("hit_and_heal", 4, 1, 0);
    pulse_heal();
    chk_st("heal_in_iframe", 5, 1, 0);
    run_frames(60);
    chk_st("expire4", 5, 0, 0);
    for (int n = 4; n >= 1; n--) begin
      pulse_hit();
      chk_st("hit_down", n, 1, 0);
      run_frames(60);
    end
    chk_st("hp1", 1, 0, 0);
    run_table(1);
    pulse_hit();
    chk_st("dead", 0, 0, 1);
    pulse_hit();
    pulse_heal();
    chk_st("dead_hold", 0, 0, 1);
    game_on = 0;
    step();
    k_idle = 1; k_dead = 0; k_hp = 8;
    chk_st("game_off", 8, 0, 0);
    game_on = 1;
    step();
    k_idle = 0;
    player_hit = 1;
    step();
    model_hit();
    chk_st("hit_held", 7, 1, 0);
    run_frames(3);
    rst = 1;
    step();
    k_idle = 1; k_inv = 0; k_hp = 8;
    chk_st("rst_mid_iframe", 8, 0, 0);
    chk("rst_rgb", rgb_out, 12'h000);
    rst = 0;
    step();
    k_idle = 0;
    repeat (3) step();
    chk_st("held_no_fire", 8, 0, 0);
    player_hit = 0;
    step();
    player_hit = 1;
    step();
    model_hit();
    chk_st("refire", 7, 1, 0);
    player_hit = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
